mux_op_arbiter: RTL and testbench
=================================

// Module: mux_op_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one mux_operation ALU (add/sub/mul) between NUM_REQ requesters.
//  Grants one request, loads operands into the ALU, waits for the ALU result and returns it to the winner.
//  Sits between requester logic and the single ALU instance; owns all ALU input ports.
// PARAMETERS
//  NUM_REQ        4    number of requesters (2..8)
//  TIMEOUT_CYCLES 16   WAIT-state cycle limit before error (used only with MUX_OP_TIMEOUT_EN)
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  rst          in   1           synchronous reset, active-high
//  req_valid    in   NUM_REQ     per-requester request; held until matching req_ready seen
//  req_a        in   NUM_REQ*32  operand A, requester i in bits [32*i+:32]
//  req_b        in   NUM_REQ*32  operand B, same packing
//  req_op       in   NUM_REQ*4   op code (0 add, 1 sub, 2 mul), requester i in [4*i+:4]
//  req_ready    out  NUM_REQ     one-hot 1-cycle accept pulse to granted requester
//  rsp_valid    out  NUM_REQ     one-hot 1-cycle result pulse to granted requester
//  rsp_data     out  32          result, valid while any rsp_valid bit high
//  rsp_err      out  1           error flag, valid with rsp_valid
//  busy         out  1           high in every state except IDLE
//  alu_a/alu_b  out  32 each     ALU operands
//  alu_s        out  4           ALU op select
//  alu_r_ready  out  1           ALU load strobe
//  alu_w_ready  in   1           ALU result-valid level
//  alu_ans      in   32          ALU result
// BEHAVIOUR
//  - All outputs registered; rst forces state IDLE, every output 0, rr pointer = NUM_REQ-1 (req 0 highest priority).
//  - FSM IDLE->LOAD->WAIT->DONE->IDLE.
//  - IDLE: if |req_valid, pick winner g round-robin starting at ptr+1 (mod NUM_REQ).
//    Latch g, req_a/b/op[g] into alu_a/b/s; next state LOAD. ptr<=g.
//  - LOAD (1 cycle): alu_r_ready=1, req_ready[g]=1. alu_w_ready is ignored in this cycle (stale from the previous op).
//  - WAIT: alu_r_ready=0. On alu_w_ready=1, capture alu_ans into rsp_data, rsp_err=0, go DONE.
//  - DONE (1 cycle): rsp_valid[g]=1, then IDLE.
//  - Latency: request sampled in cycle t -> req_ready cycle t+1 -> rsp_valid cycle t+4.
//    Back-to-back grant earliest: req_ready at t+6.
//  - req_valid changes while busy are ignored; a requester re-asserting after rsp_valid is eligible in the next IDLE.
//  - Op codes >2: ALU never raises w_ready; behaviour per CONFIGURATION.
//  - Arithmetic width: 32-bit, wraps mod 2^32 (mul keeps low 32 bits); the arbiter passes data through unmodified.
//  - rst mid-operation: in-flight request dropped, no rsp_valid. The ALU has no reset; the first LOAD after reset reinitialises it.
// CONFIGURATION
//  MUX_OP_TIMEOUT_EN defined: WAIT counts cycles.
//    After TIMEOUT_CYCLES cycles without alu_w_ready, go DONE with rsp_data=0, rsp_err=1.
//    Counter clears on LOAD.
//  MUX_OP_TIMEOUT_EN undefined: WAIT persists until alu_w_ready; rsp_err is tied 0; an invalid op hangs the arbiter until rst.
// STRUCTURE
//  - Package mux_op_pkg: op code localparams (OP_ADD=4'd0, OP_SUB=4'd1, OP_MUL=4'd2), state encodings ST_IDLE/ST_LOAD/ST_WAIT/ST_DONE.
//  - Sub-module rr_arbiter (inputs: req vector + ptr; outputs: one-hot grant + index), combinational, parameterised on NUM_REQ.
//  - Top level holds the FSM, operand registers, timeout counter and rsp registers.
// TESTING
//  1. Single req: rst, req_valid=0001, A=5, B=3, op=0 -> req_ready=0001 at t+1; rsp_valid=0001, rsp_data=8 at t+4.
//  2. Sub/mul wrap: A=3, B=5, op=1 -> rsp_data=32'hFFFFFFFE; A=32'h10000, B=32'h10000, op=2 -> rsp_data=0.
//  3. Fairness: req_valid=1111 held, each requester re-asserts after its rsp -> grant order 0,1,2,3,0, with no starvation.
//  4. Reset mid-op: rst asserted during WAIT -> all outputs 0 next cycle, no rsp_valid.
//     New req after reset -> correct result (e.g. 7+1=8).
//  5. Invalid op=4'd7 with MUX_OP_TIMEOUT_EN -> rsp_valid with rsp_err=1, rsp_data=0 after TIMEOUT_CYCLES in WAIT; next request served normally.
//  6. Busy ignore: req_valid=0010 asserted while serving req 0 -> no req_ready[1] until IDLE, then granted.

Source files
------------

// File: rtl/mux_op_pkg.sv
// Shared definitions for the mux_op ALU arbiter.
// Holds the ALU op codes and the sequencer state encoding.
package mux_op_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward (mod NUM_REQ).
// Ports: req (request vector), ptr (last winner) -> gnt (one-hot), idx, any.
module rr_arbiter
  import mux_op_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_op_arbiter.sv
// Round-robin sequencer sharing one add/sub/mul ALU between NUM_REQ requesters.
// Ports: req_* in, req_ready/rsp_* out, busy, alu_a/b/s/r_ready out,
// alu_w_ready/alu_ans in. Define MUX_OP_TIMEOUT_EN to enable the WAIT timeout.
module mux_op_arbiter
  import mux_op_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [3:0]              alu_s,
  output logic                    alu_r_ready,
  input  logic                    alu_w_ready,
  input  logic [31:0]             alu_ans
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state, state_n;
  logic [IW-1:0]       g, g_n;
  logic [IW-1:0]       ptr, ptr_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       idx;
  logic                any;
  logic                tmo;

  logic [NUM_REQ-1:0]  rdy_n, rv_n;
  logic [31:0]         data_n, a_n, b_n;
  logic [3:0]          s_n;
  logic                err_n, rr_n, busy_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

`ifdef MUX_OP_TIMEOUT_EN
  assign tmo = (cnt >= CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n = state;
    g_n     = g;
    ptr_n   = ptr;
    cnt_n   = cnt;
    a_n     = alu_a;
    b_n     = alu_b;
    s_n     = alu_s;
    rr_n    = 1'b0;
    rdy_n   = '0;
    rv_n    = '0;
    data_n  = rsp_data;
    err_n   = rsp_err;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          state_n = ST_LOAD;
          g_n     = idx;
          ptr_n   = idx;
          a_n     = req_a[32*idx +: 32];
          b_n     = req_b[32*idx +: 32];
          s_n     = req_op[4*idx +: 4];
          rr_n    = 1'b1;
          rdy_n   = gnt;
        end
      end
      ST_LOAD: begin
        // alu_w_ready still reflects the previous op here
        state_n = ST_WAIT;
        cnt_n   = '0;
      end
      ST_WAIT: begin
        if (alu_w_ready) begin
          state_n = ST_DONE;
          data_n  = alu_ans;
          err_n   = 1'b0;
          rv_n[g] = 1'b1;
        end else if (tmo) begin
          state_n = ST_DONE;
          data_n  = '0;
          err_n   = 1'b1;
          rv_n[g] = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      g           <= '0;
      ptr         <= IW'(NUM_REQ - 1);
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_s       <= '0;
      alu_r_ready <= 1'b0;
    end else begin
      state       <= state_n;
      g           <= g_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      req_ready   <= rdy_n;
      rsp_valid   <= rv_n;
      rsp_data    <= data_n;
      rsp_err     <= err_n;
      busy        <= busy_n;
      alu_a       <= a_n;
      alu_b       <= b_n;
      alu_s       <= s_n;
      alu_r_ready <= rr_n;
    end
  end

endmodule

// File: tb/tb_mux_op_arbiter.sv
// Directed bench for mux_op_arbiter with a behavioural two-cycle ALU stub.
// Optional MUX_OP_TIMEOUT_EN changes the expected invalid-op behaviour.
module tb_mux_op_arbiter;
  import mux_op_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*4-1:0]  req_op;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            busy;
  logic [31:0]     alu_a, alu_b;
  logic [3:0]      alu_s;
  logic            alu_r_ready;
  logic            alu_w_ready = 1'b0;
  logic [31:0]     alu_ans = '0;

  logic [31:0]     la = '0, lb = '0;
  logic [3:0]      ls = '0;
  logic            pend = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_op_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_s       (alu_s),
    .alu_r_ready (alu_r_ready),
    .alu_w_ready (alu_w_ready),
    .alu_ans     (alu_ans)
  );

  // ALU stub: no reset; result level rises two edges after the load strobe
  always @(posedge clk) begin
    if (alu_r_ready) begin
      pend        <= 1'b1;
      alu_w_ready <= 1'b0;
      la          <= alu_a;
      lb          <= alu_b;
      ls          <= alu_s;
    end else if (pend) begin
      pend <= 1'b0;
      if (ls == OP_ADD) begin
        alu_ans <= la + lb;  alu_w_ready <= 1'b1;
      end else if (ls == OP_SUB) begin
        alu_ans <= la - lb;  alu_w_ready <= 1'b1;
      end else if (ls == OP_MUL) begin
        alu_ans <= la * lb;  alu_w_ready <= 1'b1;
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[4*i +: 4]  = op;
    req_valid[i]      = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdy_rsp: got %h expected 00", {req_ready, rsp_valid});
    end
    checks++;
    if (rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", rsp_data);
    end
    checks++;
    if ({rsp_err, busy, alu_r_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {rsp_err, busy, alu_r_ready});
    end
    checks++;
    if ({alu_a, alu_b, alu_s} !== 68'h0) begin
      errors++;
      $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_s});
    end
    rst = 1'b0;
  endtask

  task automatic test_single(input string nm, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] op,
                             input logic [31:0] exp);
    @(negedge clk);
    set_req(0, a, b, op);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL %s_ready: got %b expected 0001", nm, req_ready);
    end
    checks++;
    if ({alu_r_ready, alu_a, alu_b, alu_s} !== {1'b1, a, b, op}) begin
      errors++;
      $display("FAIL %s_alu_load: got %b %h %h %h expected 1 %h %h %h",
               nm, alu_r_ready, alu_a, alu_b, alu_s, a, b, op);
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_early: got rsp %b busy %b expected 0000 1", nm, rsp_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001) begin
      errors++;
      $display("FAIL %s_rsp_valid: got %b expected 0001", nm, rsp_valid);
    end
    checks++;
    if (rsp_data !== exp || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_data: got %h err %b expected %h err 0", nm, rsp_data, rsp_err, exp);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got rsp %b busy %b expected 0000 0", nm, rsp_valid, busy);
    end
  endtask

  task automatic test_fairness();
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int ngr = 0;
    int last = 0;
    int last_cyc = 0;
    int cyc = 0;
    int w;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 32'(100 + i), 32'(i), OP_ADD);
    while (ngr < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid !== 4'b0000) begin
        checks++;
        if (rsp_valid !== 4'(1 << last) || rsp_data !== 32'(100 + 2 * last)) begin
          errors++;
          $display("FAIL fair_rsp: got %b %h expected %b %h", rsp_valid, rsp_data,
                   4'(1 << last), 32'(100 + 2 * last));
        end
        req_valid = req_valid | rsp_valid;
      end
      if (req_ready !== 4'b0000) begin
        checks++;
        if (req_ready !== 4'(1 << exp_ord[ngr])) begin
          errors++;
          $display("FAIL fair_grant%0d: got %b expected %b", ngr, req_ready,
                   4'(1 << exp_ord[ngr]));
        end
        if (ngr > 0) begin
          checks++;
          if (cyc - last_cyc != 5) begin
            errors++;
            $display("FAIL fair_spacing%0d: got %0d expected 5", ngr, cyc - last_cyc);
          end
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) last = i;
        last_cyc = cyc;
        req_valid = req_valid & ~req_ready;
        ngr++;
      end
    end
    checks++;
    if (ngr != 5) begin
      errors++;
      $display("FAIL fair_timeout: got %0d grants expected 5", ngr);
    end
    req_valid = '0;
    w = 0;
    while (busy === 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int c = 0;
    @(negedge clk);
    set_req(0, 32'd9, 32'd9, OP_ADD);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, busy, alu_r_ready} !== 11'h0 ||
        {alu_a, alu_b, alu_s} !== 68'h0) begin
      errors++;
      $display("FAIL rmid_zero: got %h %h expected 0 0",
               {req_ready, rsp_valid, rsp_err, busy, alu_r_ready}, {alu_a, alu_b, alu_s});
    end
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmid_no_rsp: got %0d pulses expected 0", seen);
    end
    set_req(0, 32'd7, 32'd1, OP_ADD);
    while (rsp_valid === 4'b0000 && c < 10) begin
      @(negedge clk);
      c++;
      if (req_ready[0]) req_valid[0] = 1'b0;
    end
    checks++;
    if (c != 4 || rsp_data !== 32'd8) begin
      errors++;
      $display("FAIL rmid_after: got lat %0d data %h expected 4 00000008", c, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_invalid();
    int c = 0;
`ifndef MUX_OP_TIMEOUT_EN
    int bad = 0;
`endif
    @(negedge clk);
    set_req(0, 32'd55, 32'd66, 4'd7);
    @(negedge clk);
    req_valid = '0;
`ifdef MUX_OP_TIMEOUT_EN
    c = 1;
    while (rsp_valid === 4'b0000 && c < 40) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != TMO + 2) begin
      errors++;
      $display("FAIL inv_latency: got %0d expected %0d", c, TMO + 2);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL inv_err: got %b %b %h expected 0001 1 0", rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk);
`else
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000 || busy !== 1'b1 || rsp_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL inv_hang: got %0d bad cycles expected 0", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    set_req(0, 32'd20, 32'd3, OP_MUL);
    c = 0;
    while (rsp_valid === 4'b0000 && c < 10) begin
      @(negedge clk);
      c++;
      if (req_ready[0]) req_valid[0] = 1'b0;
    end
    checks++;
    if (c != 4 || rsp_data !== 32'd60 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL inv_next: got lat %0d data %h err %b expected 4 0000003c 0",
               c, rsp_data, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int early = 0;
    @(negedge clk);
    set_req(0, 32'd1, 32'd2, OP_ADD);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid[0] = 1'b0;
        set_req(1, 32'd4, 32'd4, OP_ADD);
      end
      if (c < 6 && req_ready[1] === 1'b1) early++;
      if (c == 4) begin
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'd3) begin
          errors++;
          $display("FAIL bi_rsp0: got %b %h expected 0001 00000003", rsp_valid, rsp_data);
        end
      end
      if (c == 6) begin
        checks++;
        if (req_ready !== 4'b0010) begin
          errors++;
          $display("FAIL bi_grant1: got %b expected 0010", req_ready);
        end
        req_valid[1] = 1'b0;
      end
      if (c == 9) begin
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'd8) begin
          errors++;
          $display("FAIL bi_rsp1: got %b %h expected 0010 00000008", rsp_valid, rsp_data);
        end
      end
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL bi_early: got %0d early grants expected 0", early);
    end
  endtask

  initial begin
    test_reset();
    test_single("add", 32'd5, 32'd3, OP_ADD, 32'd8);
    test_single("sub", 32'd3, 32'd5, OP_SUB, 32'hFFFF_FFFE);
    test_single("mul_wrap", 32'h0001_0000, 32'h0001_0000, OP_MUL, 32'h0);
    test_single("mul", 32'h0001_2345, 32'h0000_0100, OP_MUL, 32'h0123_4500);
    test_single("add_wrap", 32'hFFFF_FFFF, 32'd2, OP_ADD, 32'd1);
    test_fairness();
    test_reset_mid();
    test_invalid();
    test_busy_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
